ssd_display_arbiter: RTL and testbench

- Shares the single 4-digit seven-segment display between up to three requesters, e.g. countdown, result/best-time readout and the "FAIL" message.
- Grants one requester at a time, enforces a minimum on-screen hold time, and scans the four digits at the display tick rate.
- Sits between the reaction-timer FSM outputs and the sevenSegmentDecoder and anode pins.
- Channel switches happen only at frame boundaries, so no partially-updated frame is ever shown.

---
 rtl/ssd_display_arbiter.sv | 136 +++++++++++++
 tb/tb_ssd_display_arbiter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/ssd_display_arbiter.sv
// Shares one 4-digit seven-segment display between three requesters, scanning digits on scan_tick.
// Define SSD_ARB_ROUND_ROBIN_EN for round-robin arbitration instead of fixed priority (bit 0 highest).
module ssd_display_arbiter #(
  parameter int NUM_REQ    = 3,
  parameter int HOLD_TICKS = 1000,
  parameter int HOLD_W     = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   scan_tick,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [16*NUM_REQ-1:0]  digits_in,
  input  logic [4*NUM_REQ-1:0]   dp_in,
  output logic [NUM_REQ-1:0]     grant,
  output logic [3:0]             ssdAnode,
  output logic [3:0]             bcd,
  output logic                   dp,
  output logic                   busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] HOLD = 2'd1;
  localparam logic [1:0] OPEN = 2'd2;
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_TICKS);

  logic [1:0]        state, nxt_state;
  logic [1:0]        owner, nxt_owner;
  logic [1:0]        idx, nxt_idx;
  logic [HOLD_W-1:0] hold, nxt_hold, hold_inc;
  logic [1:0]        search_base;
  logic [1:0]        pick_ch;
  logic              pick_found;
  int                nib_lo;
  int                dp_pos;

`ifdef SSD_ARB_ROUND_ROBIN_EN
  logic [1:0] rr_ptr;

  // rr_ptr always points one past the most recent owner, so the search rotates
  assign search_base = rr_ptr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr <= 2'd0;
    end else if (scan_tick && nxt_state != IDLE) begin
      rr_ptr <= (nxt_owner == 2'(NUM_REQ - 1)) ? 2'd0 : nxt_owner + 2'd1;
    end
  end
`else
  assign search_base = 2'd0;
`endif

  // Winner search: the lowest offset from search_base with a pending request
  always_comb begin
    pick_found = 1'b0;
    pick_ch    = 2'd0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[(int'(search_base) + i) % NUM_REQ]) begin
        pick_found = 1'b1;
        pick_ch    = 2'((int'(search_base) + i) % NUM_REQ);
      end
    end
  end

  always_comb begin
    hold_inc  = (hold >= HOLD_MAX) ? HOLD_MAX : hold + 1'b1;
    nxt_state = state;
    nxt_owner = owner;
    nxt_idx   = idx + 2'd1;
    nxt_hold  = hold_inc;
    case (state)
      IDLE: begin
        nxt_idx  = 2'd0;
        nxt_hold = '0;
        if (pick_found) begin
          nxt_state = HOLD;
          nxt_owner = pick_ch;
        end
      end
      default: begin
        if (hold_inc == HOLD_MAX) begin
          nxt_state = OPEN;
        end
        // Ownership may only move on the 3->0 wrap, after the hold expires or the owner lets go
        if (idx == 2'd3 && (hold_inc == HOLD_MAX || !req[owner])) begin
          if (!pick_found) begin
            nxt_state = IDLE;
            nxt_hold  = '0;
          end else if (pick_ch != owner) begin
            nxt_owner = pick_ch;
            nxt_hold  = '0;
            nxt_state = HOLD;
          end
        end
      end
    endcase
  end

  always_comb begin
    nib_lo = 16 * int'(nxt_owner) + 12 - 4 * int'(nxt_idx);
    dp_pos = 4 * int'(nxt_owner) + 3 - int'(nxt_idx);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      owner    <= 2'd0;
      idx      <= 2'd0;
      hold     <= '0;
      grant    <= '0;
      ssdAnode <= 4'b1111;
      bcd      <= 4'd15;
      dp       <= 1'b0;
      busy     <= 1'b0;
    end else if (scan_tick) begin
      state <= nxt_state;
      owner <= nxt_owner;
      idx   <= nxt_idx;
      hold  <= nxt_hold;
      if (nxt_state == IDLE) begin
        grant    <= '0;
        ssdAnode <= 4'b1111;
        bcd      <= 4'd15;
        dp       <= 1'b0;
        busy     <= 1'b0;
      end else begin
        grant    <= NUM_REQ'(1) << nxt_owner;
        ssdAnode <= ~(4'b1000 >> nxt_idx);
        bcd      <= digits_in[nib_lo +: 4];
        dp       <= dp_in[dp_pos];
        busy     <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ssd_display_arbiter.sv
// Scoreboard bench for ssd_display_arbiter with HOLD_TICKS=8; the all-request scenario
// expects rotation when SSD_ARB_ROUND_ROBIN_EN is defined and ch0 ownership otherwise.
module tb_ssd_display_arbiter;

  typedef struct packed {
    logic [2:0] g;
    logic [3:0] an;
    logic [3:0] b;
    logic       d;
    logic       bz;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        scan_tick = 1'b0;
  logic [2:0]  req = 3'b000;
  logic [47:0] digits_in = {16'h9ABC, 16'h5678, 16'h1234};
  logic [11:0] dp_in = {4'b0100, 4'b0000, 4'b1000};
  logic [2:0]  grant;
  logic [3:0]  ssdAnode;
  logic [3:0]  bcd;
  logic        dp;
  logic        busy;

  int   total = 0;
  int   bad = 0;
  exp_t sb[$];

  localparam exp_t BLANK = '{g: 3'b000, an: 4'b1111, b: 4'hF, d: 1'b0, bz: 1'b0};

  ssd_display_arbiter #(.NUM_REQ(3), .HOLD_TICKS(8), .HOLD_W(16)) dut (
    .clk(clk), .reset(reset), .scan_tick(scan_tick), .req(req),
    .digits_in(digits_in), .dp_in(dp_in), .grant(grant), .ssdAnode(ssdAnode),
    .bcd(bcd), .dp(dp), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [2:0] g, input int i, input logic [3:0] b, input logic d);
    exp_t e;
    e.g  = g;
    e.an = ~(4'b1000 >> i);
    e.b  = b;
    e.d  = d;
    e.bz = 1'b1;
    return e;
  endfunction

  function automatic exp_t observed();
    exp_t o;
    o.g  = grant;
    o.an = ssdAnode;
    o.b  = bcd;
    o.d  = dp;
    o.bz = busy;
    return o;
  endfunction

  task automatic drive_tick();
    @(negedge clk) scan_tick = 1'b1;
    @(negedge clk) scan_tick = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    exp_t e, o;
    repeat (2) @(negedge clk);
    sb.push_back(BLANK);
    e = sb.pop_front(); o = observed(); total++;
    if (o !== e) begin bad++; $display("FAIL reset_state got=%h want=%h", o, e); end
    reset = 1'b0;
    for (int t = 0; t < 2; t++) begin
      sb.push_back(BLANK);
      drive_tick();
      e = sb.pop_front(); o = observed(); total++;
      if (o !== e) begin bad++; $display("FAIL reset_idle t=%0d got=%h want=%h", t, o, e); end
    end
  endtask

  task automatic test_single_owner();
    exp_t e, o;
    logic [3:0] b;
    apply_reset();
    req = 3'b001;
    for (int t = 0; t < 5; t++) begin
      b = 4'(1 + t % 4);
      sb.push_back(mk(3'b001, t % 4, b, (t % 4) == 0));
      drive_tick();
      e = sb.pop_front(); o = observed(); total++;
      if (o !== e) begin bad++; $display("FAIL single_owner t=%0d got=%h want=%h", t, o, e); end
    end
  endtask

  task automatic test_reset_mid_frame();
    exp_t e, o;
    apply_reset();
    req = 3'b001;
    for (int t = 0; t < 3; t++) begin
      sb.push_back(mk(3'b001, t, 4'(1 + t), t == 0));
      drive_tick();
      e = sb.pop_front(); o = observed(); total++;
      if (o !== e) begin bad++; $display("FAIL midframe_pre t=%0d got=%h want=%h", t, o, e); end
    end
    @(negedge clk);
    #2 reset = 1'b1;
    sb.push_back(BLANK);
    #1;
    e = sb.pop_front(); o = observed(); total++;
    if (o !== e) begin bad++; $display("FAIL midframe_async got=%h want=%h", o, e); end
    @(negedge clk);
    reset = 1'b0;
    req = 3'b000;
    for (int t = 0; t < 2; t++) begin
      sb.push_back(BLANK);
      drive_tick();
      e = sb.pop_front(); o = observed(); total++;
      if (o !== e) begin bad++; $display("FAIL midframe_after t=%0d got=%h want=%h", t, o, e); end
    end
  endtask

  task automatic test_hold_blocks();
    exp_t e, o;
    apply_reset();
    req = 3'b010;
    for (int t = 0; t < 9; t++) begin
      if (t == 3) req = 3'b011;
      if (t < 8) sb.push_back(mk(3'b010, t % 4, 4'(5 + t % 4), 1'b0));
      else       sb.push_back(mk(3'b001, 0, 4'd1, 1'b1));
      drive_tick();
      e = sb.pop_front(); o = observed(); total++;
      if (o !== e) begin bad++; $display("FAIL hold_block t=%0d got=%h want=%h", t, o, e); end
    end
  endtask

  task automatic test_owner_release();
    exp_t e, o;
    for (int t = 1; t < 5; t++) begin
      if (t == 2) req = 3'b010;
      if (t < 4) sb.push_back(mk(3'b001, t, 4'(1 + t), 1'b0));
      else       sb.push_back(mk(3'b010, 0, 4'd5, 1'b0));
      drive_tick();
      e = sb.pop_front(); o = observed(); total++;
      if (o !== e) begin bad++; $display("FAIL owner_release t=%0d got=%h want=%h", t, o, e); end
    end
  endtask

  task automatic test_idle_return();
    exp_t e, o;
    for (int t = 1; t < 7; t++) begin
      if (t == 2) req = 3'b000;
      if (t == 6) req = 3'b100;
      if (t < 4)      sb.push_back(mk(3'b010, t, 4'(5 + t), 1'b0));
      else if (t < 6) sb.push_back(BLANK);
      else            sb.push_back(mk(3'b100, 0, 4'h9, 1'b0));
      drive_tick();
      e = sb.pop_front(); o = observed(); total++;
      if (o !== e) begin bad++; $display("FAIL idle_return t=%0d got=%h want=%h", t, o, e); end
    end
    sb.push_back(mk(3'b100, 1, 4'hA, 1'b1));
    drive_tick();
    e = sb.pop_front(); o = observed(); total++;
    if (o !== e) begin bad++; $display("FAIL idle_return_ch2 got=%h want=%h", o, e); end
  endtask

  task automatic test_first_grant_priority();
    exp_t e, o;
    apply_reset();
    req = 3'b110;
    sb.push_back(mk(3'b010, 0, 4'd5, 1'b0));
    drive_tick();
    e = sb.pop_front(); o = observed(); total++;
    if (o !== e) begin bad++; $display("FAIL first_grant got=%h want=%h", o, e); end
  endtask

  task automatic test_all_request();
    exp_t e, o;
    int   ch, i;
    apply_reset();
    req = 3'b111;
    for (int t = 0; t < 25; t++) begin
`ifdef SSD_ARB_ROUND_ROBIN_EN
      ch = (t / 8) % 3;
`else
      ch = 0;
`endif
      i = t % 4;
      sb.push_back(mk(3'(1 << ch), i, 4'(1 + 4 * ch + i), (ch == 0 && i == 0) || (ch == 2 && i == 1)));
      drive_tick();
      e = sb.pop_front(); o = observed(); total++;
      if (o !== e) begin bad++; $display("FAIL all_request t=%0d got=%h want=%h", t, o, e); end
    end
  endtask

  initial begin
    test_reset();
    test_single_owner();
    test_reset_mid_frame();
    test_hold_blocks();
    test_owner_release();
    test_idle_return();
    test_first_grant_priority();
    test_all_request();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
